pixel_group_array_rr: RTL and testbench
=======================================

# pixel_group_array_rr

Parametrised successor of the level-0 pixel grouping stage. It partitions a PIXELS×PIXELS event array into GROUP_SIZE×GROUP_SIZE groups and latches ON/OFF events per pixel. Each group has its own round-robin arbiter that serves one event per clock while the level above enables that group. It sits between the pixel array and the next arbitration level, and reports the served pixel's in-group address, group address and polarity.

## Interface
- PIXELS, 16, array side length; must be a multiple of GROUP_SIZE.
- GROUP_SIZE, 2, group side length; power of two, ≥2.
- CONST, PIXELS/GROUP_SIZE, groups per row/column (derived).
- NUM_GROUPS, CONST*CONST, total groups (derived).
- AW, max(1,$clog2(GROUP_SIZE)), in-group address width (derived).
- GW, max(1,$clog2(CONST)), group address width (derived).
- clk_i  in  1  clock. One clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- set_i  in  [PIXELS-1:0][PIXELS-1:0][1:0]  per-pixel event levels, indexed [row][col]; bit0 = ON, bit1 = OFF.
- gnt_top_i  in  [NUM_GROUPS-1:0]  per-group enable from the upper level. Group g covers rows (g/CONST)*GROUP_SIZE onward and cols (g%CONST)*GROUP_SIZE onward.
- req_o  out  [CONST-1:0][CONST-1:0]  group has ≥1 pending event, indexed [g/CONST][g%CONST].
- valid_o  out  1  one event reported this cycle.
- gnt_o  out  [GROUP_SIZE-1:0][GROUP_SIZE-1:0]  one-hot served pixel within the group.
- x_add_o  out  AW  served pixel column within group.
- y_add_o  out  AW  served pixel row within group.
- grp_x_o  out  GW  served group column (g%CONST).
- grp_y_o  out  GW  served group row (g/CONST).
- evt_o  out  2  one-hot polarity of the served event (01 ON, 10 OFF).
- grp_release_o  out  1  served event was the last pending event of its group.
- active_o  out  1  any pending event anywhere in the array.

## Operation
- pend[row][col][1:0] register: each cycle pend ← (pend & ~clr) | set_i. If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Pixel index in group: k = r*GROUP_SIZE + c, for N = GROUP_SIZE² pixels. A pixel is eligible when its pend ≠ 0.
- Per-group arbiter state is a priority pointer ptr (index of the highest-priority pixel). Reset value is 0.
- Served group: the lowest index g with gnt_top_i[g]=1 and ≥1 eligible pixel. Only that group grants in a cycle; all other groups hold their ptr.
- Within the served group:
  - Grant the first eligible pixel scanning k = ptr, ptr+1, … mod N.
  - Report bit0 (ON) if it is set, otherwise bit1 (OFF).
  - Clear only the reported bit. A pixel with both bits set remains eligible for its OFF event on a later turn.
  - ptr ← (k+1) mod N.
- Enable dropped or no eligible pixel: no grant, no clear, ptr holds, and valid_o=0 next cycle.
- grp_release: asserted with the grant when the served group's pend, after the clear and after the same-cycle set_i, is all zero.
- req_o and active_o are derived from the pend register only, not from raw set_i.
- Multiple gnt_top_i bits set: lowest eligible enabled group wins. This is not an error.

## Timing
- All outputs registered. Reset values: every output 0, pend=0, all ptr=0.
- set_i high at edge N: pend set at N, req_o/active_o high after edge N.
- With gnt_top_i asserted during cycle N+1, the grant is decided combinationally in cycle N+1 and all report outputs are valid after edge N+1. The pend clear takes effect at the same edge.
- Latency from event to report is 2 edges; throughput is 1 event per clock.
- req_o deasserts in the cycle after the clearing edge.
- When valid_o=0, gnt_o, x_add_o, y_add_o, grp_x_o, grp_y_o, evt_o and grp_release_o are all 0.
- Async reset mid-operation clears pend, ptr and all outputs immediately. The first grant after release of reset scans from pixel 0.

## Test plan
Use PIXELS=4, GROUP_SIZE=2, giving NUM_GROUPS=4.
- **Reset:** reset_i=1 with set_i all ones → every output 0. Release reset, gnt_top_i=0 → req_o=4'b1111, active_o=1, valid_o=0.
- **Single event:** pulse set_i[3][2][0] for one cycle, then gnt_top_i=4'b1000 → after 2 edges valid_o=1, grp_y_o=1, grp_x_o=1, x_add_o=0, y_add_o=1, evt_o=01, gnt_o=4'b0100, grp_release_o=1. Next cycle req_o[1][1]=0 and active_o=0.
- **Round-robin fairness:** hold set_i high on all four pixels of group 0 (bit0), gnt_top_i=4'b0001 → served k sequence 0,1,2,3,0,1 on consecutive cycles, grp_release_o never 1.
- **Dual polarity:** set_i[0][0]=2'b11 and set_i[0][1]=2'b01 pulsed once, group 0 enabled → reports in order: (k0,01), (k1,01, release=0), (k0,10, release=1).
- **Multi-enable:** events pending in groups 1 and 2, gnt_top_i=4'b0110 → group 1 drained first, then group 2. Dropping gnt_top_i to 0 mid-drain → valid_o=0 next cycle and ptr preserved on re-enable.
- **Simultaneous set/clear:** keep set_i[0][0][0]=1 during its grant cycle → pend bit stays set and grp_release_o=0. Assert reset mid-drain → outputs 0 immediately, and the first post-reset grant is k=0.

Source files
------------

// File: rtl/pixel_group_array_rr.sv
// Pixel event array split into square groups with a round-robin arbiter per group.
// Pending events are latched per pixel; the lowest enabled non-empty group reports one event per clock.
module pixel_group_array_rr #(
  parameter int PIXELS     = 16,
  parameter int GROUP_SIZE = 2,
  localparam int CONST      = PIXELS / GROUP_SIZE,
  localparam int NUM_GROUPS = CONST * CONST,
  localparam int AW         = ($clog2(GROUP_SIZE) > 1) ? $clog2(GROUP_SIZE) : 1,
  localparam int GW         = ($clog2(CONST) > 1) ? $clog2(CONST) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [PIXELS-1:0][PIXELS-1:0][1:0]       set_i,
  input  logic [NUM_GROUPS-1:0]                    gnt_top_i,
  output logic [CONST-1:0][CONST-1:0]              req_o,
  output logic                                     valid_o,
  output logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    gnt_o,
  output logic [AW-1:0]                            x_add_o,
  output logic [AW-1:0]                            y_add_o,
  output logic [GW-1:0]                            grp_x_o,
  output logic [GW-1:0]                            grp_y_o,
  output logic [1:0]                               evt_o,
  output logic                                     grp_release_o,
  output logic                                     active_o
);

  localparam int N   = GROUP_SIZE * GROUP_SIZE;
  localparam int KW  = $clog2(N);
  localparam int NGW = ($clog2(NUM_GROUPS) > 1) ? $clog2(NUM_GROUPS) : 1;

  logic [PIXELS-1:0][PIXELS-1:0][1:0]    pend_q, pend_d;
  logic [NUM_GROUPS-1:0][KW-1:0]         ptr_q, ptr_d;
  logic [CONST-1:0][CONST-1:0]           req_q, req_d;
  logic                                  valid_q, valid_d;
  logic                                  rel_q, rel_d;
  logic                                  active_q, active_d;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0] gnt_q, gnt_d;
  logic [AW-1:0]                         x_q, x_d, y_q, y_d;
  logic [GW-1:0]                         gx_q, gx_d, gy_q, gy_d;
  logic [1:0]                            evt_q, evt_d;

  logic [NUM_GROUPS-1:0][N-1:0]          elig_s;
  logic [NUM_GROUPS-1:0]                 nonempty_s, cand_s, left_s;
  logic                                  any_s;
  logic [NGW-1:0]                        sel_g_s;
  logic [KW-1:0]                         sel_k_s;
  logic [PIXELS-1:0][PIXELS-1:0]         hit_s;
  logic [PIXELS-1:0][PIXELS-1:0][1:0]    clr_s;
  logic [1:0]                            sel_pend_s, evt_s;

  function automatic logic [NGW-1:0] lowest_set(input logic [NUM_GROUPS-1:0] v);
    logic [NGW-1:0] idx;
    idx = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) idx = v[g] ? NGW'(g) : idx;
    return idx;
  endfunction

  // First eligible index scanning upward from ptr; N is a power of two so the add wraps.
  function automatic logic [KW-1:0] rr_pick(input logic [N-1:0] elig, input logic [KW-1:0] ptr);
    logic [KW-1:0] idx, pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx   = ptr + KW'(i);
      pick  = (!found && elig[idx]) ? idx : pick;
      found = found | elig[idx];
    end
    return pick;
  endfunction

  // Group eligibility and selection of the served group and pixel.
  always_comb begin
    elig_s     = '0;
    nonempty_s = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int r = 0; r < GROUP_SIZE; r++) begin
        for (int c = 0; c < GROUP_SIZE; c++) begin
          elig_s[g][r*GROUP_SIZE+c] =
            |pend_q[(g/CONST)*GROUP_SIZE+r][(g%CONST)*GROUP_SIZE+c];
        end
      end
      nonempty_s[g] = |elig_s[g];
    end
    cand_s  = gnt_top_i & nonempty_s;
    any_s   = |cand_s;
    sel_g_s = lowest_set(cand_s);
    sel_k_s = rr_pick(elig_s[sel_g_s], ptr_q[sel_g_s]);
  end

  // Clear of the reported bit, pending update and next values of all outputs.
  always_comb begin
    hit_s      = '0;
    sel_pend_s = 2'b00;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int r = 0; r < GROUP_SIZE; r++) begin
        for (int c = 0; c < GROUP_SIZE; c++) begin
          hit_s[(g/CONST)*GROUP_SIZE+r][(g%CONST)*GROUP_SIZE+c] =
            any_s && (sel_g_s == NGW'(g)) && (sel_k_s == KW'(r*GROUP_SIZE+c));
          sel_pend_s = sel_pend_s |
            (hit_s[(g/CONST)*GROUP_SIZE+r][(g%CONST)*GROUP_SIZE+c] ?
             pend_q[(g/CONST)*GROUP_SIZE+r][(g%CONST)*GROUP_SIZE+c] : 2'b00);
        end
      end
    end
    evt_s = sel_pend_s[0] ? 2'b01 : 2'b10;

    clr_s = '0;
    for (int row = 0; row < PIXELS; row++) begin
      for (int col = 0; col < PIXELS; col++) begin
        clr_s[row][col] = hit_s[row][col] ? evt_s : 2'b00;
      end
    end
    // Set is applied after the clear so a same-cycle set keeps the bit pending.
    pend_d = (pend_q & ~clr_s) | set_i;

    left_s = '0;
    req_d  = '0;
    ptr_d  = ptr_q;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int r = 0; r < GROUP_SIZE; r++) begin
        for (int c = 0; c < GROUP_SIZE; c++) begin
          left_s[g] = left_s[g] | (|pend_d[(g/CONST)*GROUP_SIZE+r][(g%CONST)*GROUP_SIZE+c]);
        end
      end
      req_d[g/CONST][g%CONST] = left_s[g];
      ptr_d[g] = (any_s && (sel_g_s == NGW'(g))) ? sel_k_s + KW'(1) : ptr_q[g];
    end

    active_d = |pend_d;
    valid_d  = any_s;
    rel_d    = any_s && !left_s[sel_g_s];
    gnt_d    = any_s ? (N'(1) << sel_k_s) : '0;
    x_d      = any_s ? sel_k_s[AW-1:0] : '0;
    y_d      = any_s ? sel_k_s[KW-1:AW] : '0;
    gx_d     = any_s ? GW'(sel_g_s % NGW'(CONST)) : '0;
    gy_d     = any_s ? GW'(sel_g_s / NGW'(CONST)) : '0;
    evt_d    = any_s ? evt_s : 2'b00;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q   <= '0;
      ptr_q    <= '0;
      req_q    <= '0;
      valid_q  <= 1'b0;
      rel_q    <= 1'b0;
      active_q <= 1'b0;
      gnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      evt_q    <= 2'b00;
    end else begin
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      rel_q    <= rel_d;
      active_q <= active_d;
      gnt_q    <= gnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      evt_q    <= evt_d;
    end
  end

  assign req_o         = req_q;
  assign valid_o       = valid_q;
  assign gnt_o         = gnt_q;
  assign x_add_o       = x_q;
  assign y_add_o       = y_q;
  assign grp_x_o       = gx_q;
  assign grp_y_o       = gy_q;
  assign evt_o         = evt_q;
  assign grp_release_o = rel_q;
  assign active_o      = active_q;

endmodule

// File: tb/tb_pixel_group_array_rr.sv
// Directed bench for pixel_group_array_rr on a 4x4 array of 2x2 groups.
module tb_pixel_group_array_rr;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [3:0][3:0][1:0]  set_i;
  logic [3:0]            gnt_top_i;
  logic [1:0][1:0]       req_o;
  logic                  valid_o;
  logic [1:0][1:0]       gnt_o;
  logic [0:0]            x_add_o, y_add_o, grp_x_o, grp_y_o;
  logic [1:0]            evt_o;
  logic                  grp_release_o;
  logic                  active_o;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_group_array_rr #(.PIXELS(4), .GROUP_SIZE(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .set_i(set_i), .gnt_top_i(gnt_top_i),
    .req_o(req_o), .valid_o(valid_o), .gnt_o(gnt_o), .x_add_o(x_add_o),
    .y_add_o(y_add_o), .grp_x_o(grp_x_o), .grp_y_o(grp_y_o), .evt_o(evt_o),
    .grp_release_o(grp_release_o), .active_o(active_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_rep(input string tag, input int k, input int gx, input int gy,
                            input logic [1:0] evt, input logic rel);
    check({tag, "/valid"}, 32'(valid_o), 32'd1);
    check({tag, "/gnt"},   32'(gnt_o), 32'(1 << k));
    check({tag, "/x"},     32'(x_add_o), 32'(k % 2));
    check({tag, "/y"},     32'(y_add_o), 32'(k / 2));
    check({tag, "/gx"},    32'(grp_x_o), 32'(gx));
    check({tag, "/gy"},    32'(grp_y_o), 32'(gy));
    check({tag, "/evt"},   32'(evt_o), 32'(evt));
    check({tag, "/rel"},   32'(grp_release_o), 32'(rel));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "/valid"}, 32'(valid_o), 32'd0);
    check({tag, "/rep"}, 32'({gnt_o, x_add_o, y_add_o, grp_x_o, grp_y_o, evt_o, grp_release_o}), 32'd0);
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    set_i     = '0;
    gnt_top_i = 4'b0000;
    tick();
    reset_i   = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b1;
    set_i     = '1;
    gnt_top_i = 4'b0000;

    // reset with all events asserted
    tick(); tick();
    expect_idle("rst");
    check("rst/req", 32'(req_o), 32'd0);
    check("rst/active", 32'(active_o), 32'd0);
    reset_i = 1'b0;
    tick();
    check("rel/req", 32'(req_o), 32'hF);
    check("rel/active", 32'(active_o), 32'd1);
    expect_idle("rel");
    reset_i = 1'b1;
    #1;
    check("arst/req", 32'(req_o), 32'd0);
    check("arst/active", 32'(active_o), 32'd0);
    set_i = '0;
    tick();
    reset_i = 1'b0;

    // single event in group 3
    do_reset();
    set_i[3][2][0] = 1'b1;
    tick();
    check("one/req", 32'(req_o), 32'h8);
    check("one/active", 32'(active_o), 32'd1);
    expect_idle("one/e1");
    set_i = '0;
    gnt_top_i = 4'b1000;
    tick();
    expect_rep("one", 2, 1, 1, 2'b01, 1'b1);
    tick();
    check("one/req_after", 32'(req_o), 32'd0);
    check("one/active_after", 32'(active_o), 32'd0);
    expect_idle("one/after");

    // round robin with all four pixels of group 0 held
    do_reset();
    set_i[0][0][0] = 1'b1; set_i[0][1][0] = 1'b1;
    set_i[1][0][0] = 1'b1; set_i[1][1][0] = 1'b1;
    gnt_top_i = 4'b0001;
    tick();
    expect_idle("rr/e1");
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_rep($sformatf("rr%0d", i), i % 4, 0, 0, 2'b01, 1'b0);
    end

    // dual polarity
    do_reset();
    set_i[0][0] = 2'b11; set_i[0][1] = 2'b01;
    gnt_top_i = 4'b0001;
    tick();
    set_i = '0;
    tick();
    expect_rep("dual0", 0, 0, 0, 2'b01, 1'b0);
    tick();
    expect_rep("dual1", 1, 0, 0, 2'b01, 1'b0);
    tick();
    expect_rep("dual2", 0, 0, 0, 2'b10, 1'b1);
    tick();
    expect_idle("dual/end");

    // two enabled groups, pause, and a re-set k0 to expose the held pointer
    do_reset();
    set_i[0][2][0] = 1'b1; set_i[1][3][0] = 1'b1;
    set_i[2][0][1] = 1'b1; set_i[3][1][0] = 1'b1;
    tick();
    check("me/req", 32'(req_o), 32'h6);
    set_i = '0;
    gnt_top_i = 4'b0110;
    tick();
    expect_rep("me0", 0, 1, 0, 2'b01, 1'b0);
    gnt_top_i = 4'b0000;
    set_i[0][2][0] = 1'b1;
    tick();
    expect_idle("me/pause");
    set_i = '0;
    gnt_top_i = 4'b0110;
    tick();
    expect_rep("me1", 3, 1, 0, 2'b01, 1'b0);
    tick();
    expect_rep("me2", 0, 1, 0, 2'b01, 1'b1);
    tick();
    expect_rep("me3", 0, 0, 1, 2'b10, 1'b0);
    tick();
    expect_rep("me4", 3, 0, 1, 2'b01, 1'b1);
    tick();
    expect_idle("me/end");
    check("me/active", 32'(active_o), 32'd0);

    // same-cycle set and clear, then async reset mid-drain
    do_reset();
    set_i[0][0][0] = 1'b1;
    gnt_top_i = 4'b0001;
    tick();
    tick();
    expect_rep("ss0", 0, 0, 0, 2'b01, 1'b0);
    tick();
    expect_rep("ss1", 0, 0, 0, 2'b01, 1'b0);
    check("ss/req", 32'(req_o), 32'h1);
    reset_i = 1'b1;
    #1;
    expect_idle("ss/arst");
    check("ss/arst_req", 32'(req_o), 32'd0);
    check("ss/arst_active", 32'(active_o), 32'd0);
    set_i = '0;
    tick();
    reset_i = 1'b0;
    set_i[0][0][0] = 1'b1; set_i[0][1][0] = 1'b1;
    tick();
    set_i = '0;
    tick();
    expect_rep("post0", 0, 0, 0, 2'b01, 1'b0);
    tick();
    expect_rep("post1", 1, 0, 0, 2'b01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
